// File: rtl/odd_even_checker.sv
// odd_even_checker: serial parity-frame receiver.
// It takes DATA_BITS data bits MSB first, then one parity bit. For each
// completed frame it reports the data word and the parity check result,
// and it keeps a saturating count of parity errors.
module odd_even_checker #(
    parameter int unsigned DATA_BITS = 3,
    parameter bit          ODD       = 1'b0,
    parameter int unsigned ERR_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_bit,
    output logic [DATA_BITS-1:0] data,
    output logic                 out_valid,
    output logic                 parity_err,
    output logic                 busy,
    output logic [ERR_W-1:0]     err_count
);

    localparam int unsigned      CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 busy_q, busy_d;
    logic [ERR_W-1:0]     err_count_q, err_count_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: advance only on accepted bits, stall otherwise
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (DATA_BITS > 1) ? DATA : PARITY;
                end
            end
            DATA: begin
                if (in_valid && ((cnt_q + CNT_W'(1)) == CNT_LAST)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                if (in_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values: shift, running parity, frame report
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        data_d       = data_q;
        out_valid_d  = 1'b0;
        parity_err_d = 1'b0;
        err_count_d  = err_count_q;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = (shift_q << 1) | DATA_BITS'(in_bit);
                    par_d   = in_bit;
                    cnt_d   = CNT_W'(1);
                end
            end
            DATA: begin
                if (in_valid) begin
                    shift_d = (shift_q << 1) | DATA_BITS'(in_bit);
                    par_d   = par_q ^ in_bit;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (in_valid) begin
                    data_d       = shift_q;
                    out_valid_d  = 1'b1;
                    parity_err_d = par_q ^ in_bit ^ ODD;
                    cnt_d        = '0;
                    if (parity_err_d && (err_count_q != ERR_MAX)) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            data_q       <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
            err_count_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            data_q       <= data_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
            err_count_q  <= err_count_d;
        end
    end

    assign data       = data_q;
    assign out_valid  = out_valid_q;
    assign parity_err = parity_err_q;
    assign busy       = busy_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_odd_even_checker.sv
// Directed testbench for odd_even_checker: even, odd and narrow-counter instances.
module tb_odd_even_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_bit;

    logic [2:0] d_data;
    logic       d_ov, d_perr, d_busy;
    logic [7:0] d_cnt;

    logic [2:0] o_data;
    logic       o_ov, o_perr, o_busy;
    logic [7:0] o_cnt;

    logic [2:0] s_data;
    logic       s_ov, s_perr, s_busy;
    logic [1:0] s_cnt;

    int tests    = 0;
    int failed   = 0;
    int ov_count = 0;

    always #5 clk = ~clk;

    odd_even_checker #(.DATA_BITS(3), .ODD(1'b0), .ERR_W(8)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .data(d_data), .out_valid(d_ov), .parity_err(d_perr),
        .busy(d_busy), .err_count(d_cnt)
    );

    odd_even_checker #(.DATA_BITS(3), .ODD(1'b1), .ERR_W(8)) u_odd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .data(o_data), .out_valid(o_ov), .parity_err(o_perr),
        .busy(o_busy), .err_count(o_cnt)
    );

    odd_even_checker #(.DATA_BITS(3), .ODD(1'b0), .ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .data(s_data), .out_valid(s_ov), .parity_err(s_perr),
        .busy(s_busy), .err_count(s_cnt)
    );

    typedef struct {
        logic       iv;
        logic       b;
        logic       ov;
        logic [2:0] data;
        logic       perr;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later
    task automatic step(input logic iv, input logic b);
        in_valid = iv;
        in_bit   = b;
        @(posedge clk);
        #1;
        if (d_ov === 1'b1) ov_count++;
    endtask

    task automatic do_reset(input logic iv);
        reset    = 1'b1;
        step(iv, 1'b1);
        reset    = 1'b0;
        chk("rst_busy", 16'(d_busy), 16'd0);
        chk("rst_ov",   16'(d_ov),   16'd0);
        chk("rst_perr", 16'(d_perr), 16'd0);
        chk("rst_data", 16'(d_data), 16'd0);
        chk("rst_cnt",  16'(d_cnt),  16'd0);
        chk("rst_ocnt", 16'(o_cnt),  16'd0);
        chk("rst_scnt", 16'(s_cnt),  16'd0);
        in_valid = 1'b0;
        ov_count = 0;
    endtask

    task automatic send_frame(input logic [2:0] d, input logic p);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, d[2-i]);
            chk("frm_mid_ov", 16'(d_ov), 16'd0);
        end
        step(1'b1, p);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;

        // Good frame 101/p0, then two back-to-back bad frames 100/p0
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 8'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 8'd1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 8'd2};

        do_reset(1'b0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].iv, tbl[i].b);
            chk($sformatf("tbl%0d_ov", i),   16'(d_ov),   16'(tbl[i].ov));
            chk($sformatf("tbl%0d_data", i), 16'(d_data), 16'(tbl[i].data));
            chk($sformatf("tbl%0d_perr", i), 16'(d_perr), 16'(tbl[i].perr));
            chk($sformatf("tbl%0d_busy", i), 16'(d_busy), 16'(tbl[i].busy));
            chk($sformatf("tbl%0d_cnt", i),  16'(d_cnt),  16'(tbl[i].cnt));
        end
        step(1'b0, 1'b0);
        chk("tbl_tail_ov", 16'(d_ov), 16'd0);
        chk("tbl_tail_data", 16'(d_data), 16'b100);

        // Stalled frame 011/p0 with two idle cycles after every bit
        do_reset(1'b0);
        begin
            logic [3:0] bits;
            bits = 4'b0110;
            for (int i = 0; i < 4; i++) begin
                step(1'b1, bits[3-i]);
                if (i < 3) begin
                    chk("stall_busy_acc", 16'(d_busy), 16'd1);
                    chk("stall_ov_acc", 16'(d_ov), 16'd0);
                    for (int k = 0; k < 2; k++) begin
                        step(1'b0, 1'b1);
                        chk("stall_busy_gap", 16'(d_busy), 16'd1);
                        chk("stall_ov_gap", 16'(d_ov), 16'd0);
                    end
                end
            end
        end
        chk("stall_ov", 16'(d_ov), 16'd1);
        chk("stall_data", 16'(d_data), 16'b011);
        chk("stall_perr", 16'(d_perr), 16'd0);
        chk("stall_busy_end", 16'(d_busy), 16'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            chk("stall_hold_ov", 16'(d_ov), 16'd0);
            chk("stall_hold_perr", 16'(d_perr), 16'd0);
        end
        chk("stall_hold_data", 16'(d_data), 16'b011);
        chk("stall_pulses", 16'(ov_count), 16'd1);

        // Reset mid-frame, reset wins over in_valid, then a clean 001/p1 frame
        step(1'b1, 1'b1);
        chk("mid_ov1", 16'(d_ov), 16'd0);
        step(1'b1, 1'b1);
        chk("mid_ov2", 16'(d_ov), 16'd0);
        chk("mid_busy", 16'(d_busy), 16'd1);
        do_reset(1'b1);
        send_frame(3'b001, 1'b1);
        chk("mid_ov", 16'(d_ov), 16'd1);
        chk("mid_data", 16'(d_data), 16'b001);
        chk("mid_perr", 16'(d_perr), 16'd0);
        chk("mid_pulses", 16'(ov_count), 16'd1);

        // Odd convention: 111/p0 is good under odd, bad under even
        do_reset(1'b0);
        send_frame(3'b111, 1'b0);
        chk("odd_ov0", 16'(o_ov), 16'd1);
        chk("odd_perr0", 16'(o_perr), 16'd0);
        chk("odd_cnt0", 16'(o_cnt), 16'd0);
        chk("even_perr0", 16'(d_perr), 16'd1);
        send_frame(3'b111, 1'b1);
        chk("odd_perr1", 16'(o_perr), 16'd1);
        chk("odd_cnt1", 16'(o_cnt), 16'd1);
        chk("odd_data1", 16'(o_data), 16'b111);
        chk("even_perr1", 16'(d_perr), 16'd0);

        // Saturation on a 2-bit counter: 1,2,3,3,3
        do_reset(1'b0);
        begin
            logic [1:0] sat_exp;
            for (int f = 0; f < 5; f++) begin
                sat_exp = (f < 3) ? 2'(f + 1) : 2'd3;
                send_frame(3'b100, 1'b0);
                chk($sformatf("sat_ov%0d", f),  16'(s_ov),  16'd1);
                chk($sformatf("sat_cnt%0d", f), 16'(s_cnt), 16'(sat_exp));
            end
        end
        chk("sat_wide_cnt", 16'(d_cnt), 16'd5);

        // Exhaustive sweep: every data word with both parity bits, back-to-back
        do_reset(1'b0);
        begin
            logic [2:0] dv;
            logic       pv;
            logic [7:0] errs;
            errs = 8'd0;
            for (int v = 0; v < 8; v++) begin
                for (int p = 0; p < 2; p++) begin
                    dv = 3'(v);
                    pv = 1'(p);
                    send_frame(dv, pv);
                    if ((^dv) != pv) errs = errs + 8'd1;
                    chk($sformatf("sw_ov_%0d_%0d", v, p),   16'(d_ov),   16'd1);
                    chk($sformatf("sw_data_%0d_%0d", v, p), 16'(d_data), 16'(dv));
                    chk($sformatf("sw_perr_%0d_%0d", v, p), 16'(d_perr), 16'((^dv) != pv));
                end
            end
            step(1'b0, 1'b0);
            chk("sw_tail_ov", 16'(d_ov), 16'd0);
            chk("sw_pulses", 16'(ov_count), 16'd16);
            chk("sw_errcnt", 16'(d_cnt), 16'(errs));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
